// File: rtl/codec_i2c_sched.sv
// rtl/codec_i2c_sched.sv - two-requester scheduler for the codec's I2C write master
module codec_i2c_sched #(
  parameter int         CLK_Freq      = 24000000,
  parameter int         I2C_Freq      = 20000,
  parameter logic [7:0] SLAVE_ADDR    = 8'h34,
  parameter int         MAX_RETRY     = 3,
  parameter int         TIMEOUT_TICKS = 64
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iREQ0_VALID,
  input  logic [15:0] iREQ0_DATA,
  output logic        oREQ0_READY,
  output logic        oREQ0_DONE,
  output logic        oREQ0_ERR,
  input  logic        iREQ1_VALID,
  input  logic [15:0] iREQ1_DATA,
  output logic        oREQ1_READY,
  output logic        oREQ1_DONE,
  output logic        oREQ1_ERR,
  output logic        oCTRL_TICK,
  output logic [23:0] oI2C_DATA,
  output logic        oI2C_GO,
  input  logic        iI2C_END,
  input  logic        iI2C_ACK,
  output logic        oBUSY
);

  localparam int         DIV       = CLK_Freq / (2 * I2C_Freq);
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [15:0] DIV_PRE  = 16'(DIV - 2);
  localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);
  localparam logic [7:0]  TC_LIMIT  = 8'(TIMEOUT_TICKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_GAP_RETRY,
    S_GAP
  } stateType;

  stateType    state, stateNext;
  logic [15:0] divCnt;
  logic        tickReg;
  logic        go, goNext;
  logic [2:0]  rc, rcNext;
  logic [7:0]  tc, tcNext, tcInc;
  logic        last, lastNext;
  logic        owner, ownerNext;
  logic        grantIdx;
  logic [23:0] dataReg, dataNext;
  logic        rdy0, rdy1, rdy0Next, rdy1Next;
  logic        done0, done1, done0Next, done1Next;
  logic        err0, err1, err0Next, err1Next;
  logic        busy, busyNext;

  assign tcInc = tc + 8'd1;

  // Free-running divider; the tick is registered one count early so it lines up with divCnt==DIV-1
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      divCnt  <= 16'd0;
      tickReg <= 1'b0;
    end else begin
      divCnt  <= (divCnt == DIV_LAST) ? 16'd0 : divCnt + 16'd1;
      tickReg <= (divCnt == DIV_PRE);
    end
  end

  // State and registered outputs; reset aborts any attempt without reporting it
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= S_IDLE;
      go      <= 1'b0;
      rc      <= 3'd0;
      tc      <= 8'd0;
      last    <= 1'b1;
      owner   <= 1'b0;
      dataReg <= 24'h0;
      rdy0    <= 1'b0;
      rdy1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= stateNext;
      go      <= goNext;
      rc      <= rcNext;
      tc      <= tcNext;
      last    <= lastNext;
      owner   <= ownerNext;
      dataReg <= dataNext;
      rdy0    <= rdy0Next;
      rdy1    <= rdy1Next;
      done0   <= done0Next;
      done1   <= done1Next;
      err0    <= err0Next;
      err1    <= err1Next;
      busy    <= busyNext;
    end
  end

  // Round-robin grant, attempt sequencing and retry/timeout decisions
  always_comb begin
    stateNext = state;
    goNext    = go;
    rcNext    = rc;
    tcNext    = tc;
    lastNext  = last;
    ownerNext = owner;
    dataNext  = dataReg;
    rdy0Next  = 1'b0;
    rdy1Next  = 1'b0;
    done0Next = 1'b0;
    done1Next = 1'b0;
    err0Next  = 1'b0;
    err1Next  = 1'b0;
    // On a tie the requester that was not served last wins
    grantIdx  = (iREQ0_VALID && iREQ1_VALID) ? ~last : iREQ1_VALID;

    case (state)
      S_IDLE: begin
        if (iREQ0_VALID || iREQ1_VALID) begin
          ownerNext = grantIdx;
          lastNext  = grantIdx;
          dataNext  = {SLAVE_ADDR, (grantIdx ? iREQ1_DATA : iREQ0_DATA)};
          rdy0Next  = ~grantIdx;
          rdy1Next  = grantIdx;
          rcNext    = 3'd0;
          tcNext    = 8'd0;
          stateNext = S_ARM;
        end
      end
      S_ARM: begin
        if (tickReg) begin
          goNext    = 1'b1;
          tcNext    = 8'd0;
          stateNext = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tickReg) begin
          tcNext = tcInc;
          if (iI2C_END && !iI2C_ACK) begin
            goNext    = 1'b0;
            done0Next = ~owner;
            done1Next = owner;
            stateNext = S_GAP;
          end else if ((iI2C_END && iI2C_ACK) || (tcInc == TC_LIMIT)) begin
            goNext = 1'b0;
            if (rc < RETRY_MAX) begin
              rcNext    = rc + 3'd1;
              stateNext = S_GAP_RETRY;
            end else begin
              err0Next  = ~owner;
              err1Next  = owner;
              stateNext = S_GAP;
            end
          end
        end
      end
      S_GAP_RETRY: begin
        if (tickReg) begin
          stateNext = S_ARM;
        end
      end
      S_GAP: begin
        if (tickReg) begin
          stateNext = S_IDLE;
        end
      end
      default: begin
        goNext    = 1'b0;
        stateNext = S_IDLE;
      end
    endcase

    busyNext = (stateNext != S_IDLE);
  end

  assign oCTRL_TICK  = tickReg;
  assign oI2C_GO     = go;
  assign oI2C_DATA   = dataReg;
  assign oREQ0_READY = rdy0;
  assign oREQ1_READY = rdy1;
  assign oREQ0_DONE  = done0;
  assign oREQ1_DONE  = done1;
  assign oREQ0_ERR   = err0;
  assign oREQ1_ERR   = err1;
  assign oBUSY       = busy;

endmodule

// File: tb/tb_codec_i2c_sched.sv
// tb/tb_codec_i2c_sched.sv - directed self-checking bench for codec_i2c_sched
module tb_codec_i2c_sched;

  localparam int DIV = 4;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iREQ0_VALID = 1'b0;
  logic [15:0] iREQ0_DATA = 16'h0;
  logic        iREQ1_VALID = 1'b0;
  logic [15:0] iREQ1_DATA = 16'h0;
  logic        iI2C_END = 1'b0;
  logic        iI2C_ACK = 1'b0;
  logic        oREQ0_READY, oREQ0_DONE, oREQ0_ERR;
  logic        oREQ1_READY, oREQ1_DONE, oREQ1_ERR;
  logic        oCTRL_TICK, oI2C_GO, oBUSY;
  logic [23:0] oI2C_DATA;

  codec_i2c_sched #(
    .CLK_Freq(32),
    .I2C_Freq(4),
    .SLAVE_ADDR(8'h34),
    .MAX_RETRY(3),
    .TIMEOUT_TICKS(64)
  ) dut (
    .iCLK(iCLK),
    .iRST_N(iRST_N),
    .iREQ0_VALID(iREQ0_VALID),
    .iREQ0_DATA(iREQ0_DATA),
    .oREQ0_READY(oREQ0_READY),
    .oREQ0_DONE(oREQ0_DONE),
    .oREQ0_ERR(oREQ0_ERR),
    .iREQ1_VALID(iREQ1_VALID),
    .iREQ1_DATA(iREQ1_DATA),
    .oREQ1_READY(oREQ1_READY),
    .oREQ1_DONE(oREQ1_DONE),
    .oREQ1_ERR(oREQ1_ERR),
    .oCTRL_TICK(oCTRL_TICK),
    .oI2C_DATA(oI2C_DATA),
    .oI2C_GO(oI2C_GO),
    .iI2C_END(iI2C_END),
    .iI2C_ACK(iI2C_ACK),
    .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  int nChecks = 0;
  int nPass = 0;
  int nDone0 = 0, nDone1 = 0, nErr0 = 0, nErr1 = 0;
  int nGoRise = 0;
  int lowTicks = 0;
  logic goPrev = 1'b0;
  int gapLog [0:63];
  logic [23:0] dataLog [0:63];

  // Pulse counters and per-GO-rise history, sampled on the pre-edge values
  always @(posedge iCLK) begin
    if (oREQ0_DONE) nDone0++;
    if (oREQ1_DONE) nDone1++;
    if (oREQ0_ERR) nErr0++;
    if (oREQ1_ERR) nErr1++;
    if (oCTRL_TICK && !oI2C_GO) lowTicks++;
    if (oI2C_GO && !goPrev) begin
      nGoRise++;
      if (nGoRise < 64) begin
        gapLog[nGoRise] = lowTicks;
        dataLog[nGoRise] = oI2C_DATA;
      end
      lowTicks = 0;
    end
    goPrev = oI2C_GO;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic waitTick();
    int n = 0;
    do begin
      step();
      n++;
    end while (!oCTRL_TICK && n < 50);
    if (!oCTRL_TICK) checkVal("tick_bound", 0, 1);
  endtask

  task automatic waitGo();
    int n = 0;
    while (!oI2C_GO && n < 100) begin
      step();
      n++;
    end
    if (!oI2C_GO) checkVal("go_bound", 0, 1);
  endtask

  task automatic waitGoLow();
    int n = 0;
    while (oI2C_GO && n < 400) begin
      step();
      n++;
    end
    if (oI2C_GO) checkVal("go_low_bound", 1, 0);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (oBUSY && n < 100) begin
      step();
      n++;
    end
    if (oBUSY) checkVal("idle_bound", 1, 0);
  endtask

  task automatic waitReady(output int who);
    int n = 0;
    while (!oREQ0_READY && !oREQ1_READY && n < 100) begin
      step();
      n++;
    end
    who = oREQ1_READY ? 1 : (oREQ0_READY ? 0 : -1);
    if (who < 0) checkVal("ready_bound", 0, 1);
  endtask

  // With GO high, assert END on the n-th WAIT tick; returns in the cycle after the deciding tick
  task automatic finishAttempt(input int n, input logic ack);
    for (int i = 1; i < n; i++) waitTick();
    step();
    iI2C_END = 1'b1;
    iI2C_ACK = ack;
    waitTick();
    step();
    iI2C_END = 1'b0;
    iI2C_ACK = 1'b0;
  endtask

  task automatic respond(input int n, input logic ack);
    waitGo();
    finishAttempt(n, ack);
  endtask

  int who;
  int base, bDone0, bDone1, bErr0, bErr1;

  initial begin
    // Reset state and first tick position
    step();
    step();
    checkVal("rst_outputs", {oI2C_GO, oBUSY, oCTRL_TICK, oREQ0_READY, oREQ1_READY,
                             oREQ0_DONE, oREQ1_DONE, oREQ0_ERR, oREQ1_ERR}, 0);
    checkVal("rst_data", oI2C_DATA, 24'h0);
    iRST_N = 1'b1;
    for (int k = 1; k < DIV; k++) begin
      step();
      if (k == DIV - 2) checkVal("rst_tick_early", oCTRL_TICK, 0);
      if (k == DIV - 1) checkVal("rst_tick_first", oCTRL_TICK, 1);
    end

    // Single write from requester 0
    bDone0 = nDone0; bErr0 = nErr0; base = nGoRise;
    iREQ0_DATA = 16'h0C00;
    iREQ0_VALID = 1'b1;
    step();
    checkVal("w_ready0", {oREQ0_READY, oREQ1_READY}, 2'b10);
    checkVal("w_data", oI2C_DATA, 24'h340C00);
    checkVal("w_busy", oBUSY, 1);
    iREQ0_VALID = 1'b0;
    iREQ0_DATA = 16'hFFFF;
    step();
    checkVal("w_ready_once", oREQ0_READY, 0);
    waitTick();
    checkVal("w_go_before_tick", oI2C_GO, 0);
    step();
    checkVal("w_go_after_tick", oI2C_GO, 1);
    finishAttempt(5, 1'b0);
    checkVal("w_done_pulse", {oREQ0_DONE, oREQ0_ERR, oI2C_GO}, 3'b100);
    checkVal("w_data_hold", oI2C_DATA, 24'h340C00);
    waitIdle();
    checkVal("w_done_count", nDone0 - bDone0, 1);
    checkVal("w_err_count", nErr0 - bErr0, 0);
    checkVal("w_go_count", nGoRise - base, 1);

    // Tie from reset and alternating grants with both requesters held valid
    iRST_N = 1'b0;
    iREQ0_DATA = 16'h0479;
    iREQ1_DATA = 16'h1201;
    iREQ0_VALID = 1'b1;
    iREQ1_VALID = 1'b1;
    step();
    iRST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitReady(who);
      checkVal($sformatf("rr_owner%0d", i), who, i % 2);
      checkVal($sformatf("rr_data%0d", i), oI2C_DATA, (i % 2) ? 24'h341201 : 24'h340479);
      if (i == 3) begin
        iREQ0_VALID = 1'b0;
        iREQ1_VALID = 1'b0;
      end
      respond(1, 1'b0);
      checkVal($sformatf("rr_done%0d", i), {oREQ1_DONE, oREQ0_DONE}, (i % 2) ? 2'b10 : 2'b01);
    end
    waitIdle();

    // Two NACKs then success for requester 1
    bDone1 = nDone1; bErr1 = nErr1; base = nGoRise;
    iREQ1_DATA = 16'h0A55;
    iREQ1_VALID = 1'b1;
    waitReady(who);
    iREQ1_VALID = 1'b0;
    respond(3, 1'b1);
    checkVal("rt_nack1", {oI2C_GO, oBUSY, oREQ1_DONE, oREQ1_ERR}, 4'b0100);
    respond(3, 1'b1);
    respond(3, 1'b0);
    checkVal("rt_done", {oREQ1_DONE, oREQ1_ERR}, 2'b10);
    waitIdle();
    checkVal("rt_go_count", nGoRise - base, 3);
    for (int i = 1; i <= 3; i++)
      checkVal($sformatf("rt_data%0d", i), dataLog[base + i], 24'h340A55);
    checkVal("rt_gap2", gapLog[base + 2] >= 2, 1);
    checkVal("rt_gap3", gapLog[base + 3] >= 2, 1);
    checkVal("rt_done_count", nDone1 - bDone1, 1);
    checkVal("rt_err_count", nErr1 - bErr1, 0);

    // Every attempt NACKed: four attempts then ERR
    bDone0 = nDone0; bErr0 = nErr0; base = nGoRise;
    iREQ0_DATA = 16'h1F00;
    iREQ0_VALID = 1'b1;
    waitReady(who);
    iREQ0_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      respond(2, 1'b1);
      checkVal($sformatf("ex_err%0d", i), {oREQ0_ERR, oREQ0_DONE}, (i == 3) ? 2'b10 : 2'b00);
    end
    waitIdle();
    repeat (3 * DIV) step();
    checkVal("ex_go_count", nGoRise - base, 4);
    checkVal("ex_err_count", nErr0 - bErr0, 1);
    checkVal("ex_done_count", nDone0 - bDone0, 0);

    // END never arrives: timeout after 64 WAIT ticks, four times
    bDone1 = nDone1; bErr1 = nErr1; base = nGoRise;
    iREQ1_DATA = 16'h0203;
    iREQ1_VALID = 1'b1;
    waitReady(who);
    iREQ1_VALID = 1'b0;
    waitGo();
    for (int i = 0; i < 63; i++) waitTick();
    step();
    checkVal("to_go_held", oI2C_GO, 1);
    waitTick();
    step();
    checkVal("to_go_drop", {oI2C_GO, oBUSY}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      waitGo();
      waitGoLow();
    end
    checkVal("to_err_pulse", oREQ1_ERR, 1);
    waitIdle();
    checkVal("to_go_count", nGoRise - base, 4);
    checkVal("to_err_count", nErr1 - bErr1, 1);
    checkVal("to_done_count", nDone1 - bDone1, 0);

    // Reset while GO is high with requester 1 pending
    bDone0 = nDone0; bErr0 = nErr0; bDone1 = nDone1;
    iREQ0_DATA = 16'h0101;
    iREQ0_VALID = 1'b1;
    waitReady(who);
    iREQ0_VALID = 1'b0;
    waitGo();
    iREQ1_DATA = 16'h0707;
    iREQ1_VALID = 1'b1;
    waitTick();
    waitTick();
    step();
    #2;
    iRST_N = 1'b0;
    #1;
    checkVal("mr_async", {oI2C_GO, oBUSY, oREQ1_READY}, 3'b000);
    checkVal("mr_data", oI2C_DATA, 24'h0);
    step();
    iRST_N = 1'b1;
    for (int k = 1; k < DIV; k++) begin
      step();
      if (k == 1) begin
        checkVal("mr_grant1", {oREQ1_READY, oREQ0_READY}, 2'b10);
        checkVal("mr_data1", oI2C_DATA, 24'h340707);
        iREQ1_VALID = 1'b0;
      end
      if (k == DIV - 2) checkVal("mr_tick_early", oCTRL_TICK, 0);
      if (k == DIV - 1) checkVal("mr_tick_first", oCTRL_TICK, 1);
    end
    respond(1, 1'b0);
    checkVal("mr_done1", {oREQ1_DONE, oREQ0_DONE}, 2'b10);
    waitIdle();
    checkVal("mr_no_stale", (nDone0 - bDone0) + (nErr0 - bErr0), 0);
    checkVal("mr_done1_count", nDone1 - bDone1, 1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
